// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use / multi-cycle hazard control.
// Define FWD_STALL_CNT_EN to build the saturating stall-cycle counter.

module fwd_hazard_src #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] ex_src,
  input  logic [ADDR_W-1:0] id_src,
  input  logic              id_used,
  input  logic [ADDR_W-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [ADDR_W-1:0] memwb_rd,
  input  logic              memwb_we,
  input  logic [ADDR_W-1:0] idex_rd,
  input  logic [ADDR_W-1:0] busy_rd,
  output logic [1:0]        sel,
  output logic              ld_match,
  output logic              mc_match
);
  always_comb begin
    sel = 2'b00;
    if (exmem_we && exmem_rd != '0 && exmem_rd == ex_src)      sel = 2'b10;
    else if (memwb_we && memwb_rd != '0 && memwb_rd == ex_src) sel = 2'b01;
  end

  assign ld_match = id_used && idex_rd != '0 && id_src == idex_rd;
  assign mc_match = id_used && busy_rd != '0 && id_src == busy_rd;
endmodule

module fwd_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr,
  input  logic [ADDR_W-1:0]         idex_rd_addr,
  input  logic                      idex_mem_read,
  input  logic [ADDR_W-1:0]         exmem_rd_addr,
  input  logic                      exmem_reg_write,
  input  logic [ADDR_W-1:0]         memwb_rd_addr,
  input  logic                      memwb_reg_write,
  input  logic                      mc_start,
  input  logic [ADDR_W-1:0]         mc_rd_addr,
  input  logic                      mc_done,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic                      mc_err,
  output logic [31:0]               stall_cnt
);
  typedef enum logic [1:0] {RUN, LOAD_HOLD, MC_HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_v_q, busy_v_d;
  logic [ADDR_W-1:0]   busy_rd_q, busy_rd_d;
  logic                mc_err_q, mc_err_d;

  logic [NUM_SRC-1:0][1:0] sel_v;
  logic [NUM_SRC-1:0]      ld_match_v, mc_match_v;
  logic                    ld_haz, mc_haz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_hazard_src #(.ADDR_W(ADDR_W)) u_src (
      .ex_src   (ex_src_addr[i*ADDR_W +: ADDR_W]),
      .id_src   (id_src_addr[i*ADDR_W +: ADDR_W]),
      .id_used  (id_src_used[i]),
      .exmem_rd (exmem_rd_addr),
      .exmem_we (exmem_reg_write),
      .memwb_rd (memwb_rd_addr),
      .memwb_we (memwb_reg_write),
      .idex_rd  (idex_rd_addr),
      .busy_rd  (busy_rd_q),
      .sel      (sel_v[i]),
      .ld_match (ld_match_v[i]),
      .mc_match (mc_match_v[i])
    );
  end

  assign fwd_sel = sel_v;
  assign ld_haz  = idex_mem_read && |ld_match_v;
  assign mc_haz  = busy_v_q && |mc_match_v;
  assign mc_err  = mc_err_q;

  // Hold sequencer; a pending multi-cycle result outranks a load-use hazard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (mc_haz) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = MC_HOLD;
        end else if (ld_haz) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = LOAD_HOLD;
            cnt_d   = 4'(LOAD_STALL - 2);
          end
        end
      end
      LOAD_HOLD: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      MC_HOLD: begin
        stall  = !mc_done;
        bubble = !mc_done;
        if (mc_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A start in the same cycle as done replaces the retiring entry.
  always_comb begin
    busy_v_d  = busy_v_q;
    busy_rd_d = busy_rd_q;
    mc_err_d  = mc_err_q;
    if (mc_start && busy_v_q && !mc_done) begin
      mc_err_d = 1'b1;
    end else if (mc_start) begin
      busy_v_d  = 1'b1;
      busy_rd_d = mc_rd_addr;
    end else if (mc_done) begin
      busy_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      busy_v_q  <= 1'b0;
      busy_rd_q <= '0;
      mc_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_v_q  <= busy_v_d;
      busy_rd_q <= busy_rd_d;
      mc_err_q  <= mc_err_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-control unit for the 5-stage pipelined CPU. It generalises EX-stage operand forwarding to `NUM_SRC` source operands and `ADDR_W`-bit register addresses. It adds sequential hazard control: load-use stalls of configurable length, and a one-entry scoreboard for a long-latency multi-cycle unit (MUL/DIV). It sits beside the ID and EX stages, drives the EX operand muxes, and drives PC/IF-ID hold plus ID/EX bubble insertion.

## Interface
- `ADDR_W`, 5, register address width
- `NUM_SRC`, 2, source operands per instruction; source `i` occupies bits `[i*ADDR_W +: ADDR_W]`
- `LOAD_STALL`, 1, stall cycles per load-use hazard, range 1..15

- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `id_src_addr`  in  NUM_SRC*ADDR_W  ID-stage source addresses
- `id_src_used`  in  NUM_SRC  source `i` is actually read by the ID instruction
- `ex_src_addr`  in  NUM_SRC*ADDR_W  EX-stage source addresses
- `idex_rd_addr`, `idex_mem_read`  in  ADDR_W, 1  ID/EX destination; ID/EX instruction is a load
- `exmem_rd_addr`, `exmem_reg_write`  in  ADDR_W, 1  EX/MEM destination and write enable
- `memwb_rd_addr`, `memwb_reg_write`  in  ADDR_W, 1  MEM/WB destination and write enable
- `mc_start`, `mc_rd_addr`  in  1, ADDR_W  multi-cycle op issued from EX this cycle, with its destination
- `mc_done`  in  1  multi-cycle result written to the register file this cycle
- `fwd_sel`  out  2*NUM_SRC  per-source select: 00 register file, 01 MEM/WB, 10 EX/MEM
- `stall`  out  1  hold PC and IF/ID
- `bubble`  out  1  zero ID/EX control signals
- `mc_err`  out  1  sticky protocol error
- `stall_cnt`  out  32  stall-cycle counter (see Configuration)

## Operation
- **Forwarding** (combinational, per source `i`):
  - 10 if `exmem_reg_write`, `exmem_rd_addr` != 0 and it equals the source.
  - Otherwise 01 if the same conditions hold for the MEM/WB fields.
  - Otherwise 00. EX/MEM always wins over MEM/WB.
- **Hazard terms.** A source `i` "matches" an address A when `id_src_used[i]`, A != 0, and `id_src_addr[i]` == A.
  - `ld_haz`: `idex_mem_read` and some source matches `idex_rd_addr`.
  - `mc_haz`: `busy_v` and some source matches `busy_rd`.
- **Scoreboard.**
  - `mc_start` sets `busy_v` and loads `busy_rd` = `mc_rd_addr`.
  - `mc_done` clears `busy_v`. If `mc_start` and `mc_done` occur in the same cycle, the start wins: the new entry is loaded.
  - `mc_start` while `busy_v` && !`mc_done` is ignored and sets `mc_err` until reset.
- **FSM states:** RUN, LOAD_HOLD, MC_HOLD. Internal counter `cnt` is 4 bits.
  - RUN, `mc_haz`: `stall`=1, `bubble`=1, go to MC_HOLD. `mc_haz` has priority over `ld_haz`.
  - RUN, `ld_haz`: `stall`=1, `bubble`=1. If `LOAD_STALL` > 1, go to LOAD_HOLD with `cnt` = `LOAD_STALL`-2; otherwise stay in RUN.
  - LOAD_HOLD: `stall`=1, `bubble`=1. When `cnt` == 0, go to RUN; otherwise decrement `cnt`.
  - MC_HOLD: `stall`=`bubble`=!`mc_done`. On `mc_done`, go to RUN. The register file writes before it reads, so ID picks up the result in that same cycle.
  - RUN with no hazard: `stall`=`bubble`=0.
- `fwd_sel` is evaluated every cycle, including stall cycles.

## Timing
- `fwd_sel`, `stall`, `bubble`: combinational from the inputs and current state, with zero latency.
- Load-use hazard: `stall` is high for exactly `LOAD_STALL` consecutive cycles, starting in the detection cycle.
- Multi-cycle hazard: `stall` is high from detection until the `mc_done` cycle, exclusive of that cycle.
- Reset values:
  - State RUN, `cnt`=0, `busy_v`=0, `busy_rd`=0, `mc_err`=0, `stall_cnt`=0.
  - Consequently `stall`=`bubble`=0 whenever the hazard inputs are inactive.
  - Reset asserted mid-hold abandons the hold immediately and asynchronously.
- Address 0 never forwards, never stalls, and is never tracked as busy. `mc_rd_addr`=0 sets `busy_v`, but `mc_haz` stays 0.

## Configuration
- `FWD_STALL_CNT_EN` defined: `stall_cnt` increments on every cycle with `stall`=1 and saturates at 32'hFFFF_FFFF.
- `FWD_STALL_CNT_EN` undefined: the counter is not built and `stall_cnt` is tied to 0.
- The port list is identical in both builds.

## Test plan
- Forwarding priority: EX/MEM rd=3 (write), MEM/WB rd=3 (write), `ex_src_addr[0]`=3 -> `fwd_sel[1:0]`=10. Repeat with the EX/MEM write disabled -> 01. Repeat with rd=0 in both stages -> 00.
- Load-use, `LOAD_STALL`=1: ID/EX load rd=5, ID src1=5 used -> `stall`=`bubble`=1 for exactly 1 cycle. Same case with `id_src_used`=0 -> no stall.
- Load-use, `LOAD_STALL`=3: same hazard -> `stall` high for exactly 3 cycles, then RUN. With `FWD_STALL_CNT_EN` defined, `stall_cnt`=3.
- Multi-cycle: `mc_start` rd=7, ID src0=7 on the next cycle -> stall held until `mc_done`. `stall` is 0 in the `mc_done` cycle and the state returns to RUN.
- Scoreboard edges:
  - `mc_start` while busy -> `mc_err`=1 and remains 1.
  - Simultaneous `mc_done` and `mc_start` rd=9 -> `busy_rd`=9 and `busy_v`=1.
  - `mc_haz` and `ld_haz` asserted together -> MC_HOLD is taken.
- Async reset: assert `rst_i` between clock edges during LOAD_HOLD -> `stall`=0, `mc_err`=0, `stall_cnt`=0 immediately.
